nf_dev_if: RTL and testbench
============================

Name: nf_dev_if

Overview:
Device-side (target) end of the NAND flash bus driven by nfc_if: oversamples CLE/ALE/WE#/RE# on the system clock and decodes command, address and data-in cycles. It also serves data-out and status bytes and drives R/B#. It sits between the NAND pins and a backend page-buffer/array model, and is the counterpart the nfc_if bench and FPGA loopback use in place of a real flash die.

Parameters:
DAT_WID, 8, NAND bus and data byte width
COL_CYC, 2, column address cycles
ROW_CYC, 3, row address cycles
BUSY_CYC, 64, clk cycles R/B# held low after 0x30, 0x10 or 0xFF
CNT_WID, 14, data byte counter width

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
nf_cle  in  1  command latch enable
nf_ale  in  1  address latch enable
nf_web  in  1  write strobe, active low; data latched on rising edge
nf_reb  in  1  read strobe, active low; data advanced on falling edge
nf_wpb  in  1  write protect, active low
nf_din  in  DAT_WID  bus data from controller
nf_dout  out  DAT_WID  bus data to controller
nf_dir  out  1  1 = device drives bus (data-out/status phase)
nf_rb  out  1  ready/busy, 0 = busy
dev_cmd_vld  out  1  one-clk pulse per latched command
dev_cmd  out  DAT_WID  last latched command
dev_addr_vld  out  1  one-clk pulse when address phase closes
dev_col_addr  out  8*COL_CYC  assembled column address
dev_row_addr  out  8*ROW_CYC  assembled row address
dev_addr_cnt  out  3  bytes received in the closed address phase
dev_wdat_vld  out  1  one-clk pulse per data-in byte
dev_wdat  out  DAT_WID  data-in byte
dev_rdat_rd  out  1  one-clk pulse: backend advances to next read byte
dev_rdat  in  DAT_WID  current backend read byte
dev_dat_cnt  out  CNT_WID  bytes transferred in current data phase
dev_prog_done  out  1  one-clk pulse at busy end after 0x10

Behaviour:
- Reset: nf_dout=0, nf_dir=0, nf_rb=1, all dev_* pulses=0, dev_cmd=0, addresses=0, dev_addr_cnt=0, dev_dat_cnt=0, FSM=IDLE, status=8'hE0 with bit7 = nf_wpb.
- Sync: nf_cle, nf_ale, nf_web, nf_reb and nf_din go through 2-flop synchronizers as one aligned group. WE# rise = sync_web & ~sync_web_d; RE# fall = ~sync_reb & sync_reb_d. Each event acts on the 3rd clk edge after the pin edge, so the controller must hold strobes and data at least 3 clk (tconf ≥ 3).
- WE# rise decode, using synced CLE/ALE:
  - CLE=1, ALE=0: command cycle; dev_cmd updated, dev_cmd_vld pulse.
  - ALE=1, CLE=0: address byte k; k<COL_CYC goes to col[8k+:8], else row[8(k-COL_CYC)+:8]. Bytes beyond COL_CYC+ROW_CYC are dropped.
  - Both 0: data-in byte.
  - Both 1: ignored.
- Address phase closes on the next command or data cycle, or immediately once COL_CYC+ROW_CYC bytes are received. On close: dev_addr_vld pulse, dev_addr_cnt = bytes received (saturates at 7).
- FSM states: IDLE, ADDR, DIN, BUSY, DOUT, STAT.
  - 0x00 → ADDR.
  - 0x80 → ADDR, then DIN. dev_wdat_vld only in DIN with nf_wpb=1; bytes are discarded when nf_wpb=0.
  - 0x30 → BUSY, then DOUT.
  - 0x10 → BUSY, then IDLE with dev_prog_done pulse.
  - 0x70 → STAT; the previous phase is remembered. STAT returns status on every RE#, and the next command (e.g. 0x00) resumes DOUT.
  - 0xFF from any state, including BUSY → BUSY; counters and addresses cleared, then IDLE.
  - Any other command: pulse only, FSM → IDLE.
- BUSY: nf_rb=0 exactly BUSY_CYC clks, starting the clk after the command event. WE#/RE# events other than 0xFF are ignored; status bit6 = 0 while busy.
- DOUT:
  - nf_dir=1 while in DOUT/STAT.
  - On each RE# fall: nf_dout <= dev_rdat registered, dev_rdat_rd pulse same clk, dev_dat_cnt+1.
  - Counter wraps at 2^CNT_WID.
- STAT: nf_dout <= status on each RE# fall; no dev_rdat_rd.
- dev_dat_cnt clears on every command.
- WE# and RE# events in the same clk: WE# wins, RE# dropped.
- Reset asserted mid-phase: immediate return to reset values.

Decomposition:
- Shared nfc_parameter.v holds: DAT_WID, command opcodes (CMD_READ0=00, CMD_READ1=30, CMD_PROG0=80, CMD_PROG1=10, CMD_STAT=70, CMD_RST=FF) and FSM state encodings.
- One sub-module, nf_strb_sync: 2-flop synchronizer plus edge detect for the strobe/data group, outputs aligned we_rise, re_fall, cle, ale, din.

Test Plan:
- Reset, then CLE + WE# with din=8'h70 → dev_cmd_vld one pulse, dev_cmd=70. Next 2 RE# → nf_dout=E0|{wp,..} each, nf_dir=1.
- 0x00, then addr bytes 02,03,AA,55,CC, then 0x30 → dev_col_addr=16'h0302, dev_row_addr=24'hCC55AA, dev_addr_cnt=5. nf_rb low exactly 64 clk, then 16 RE# → 16 dev_rdat_rd pulses, dev_dat_cnt=16.
- 0x80, 5 addr bytes, 16 data bytes 1..16, 0x10 → 16 dev_wdat_vld pulses carrying 1..16, busy 64 clk, dev_prog_done one pulse.
- Same program with nf_wpb=0 → no dev_wdat_vld; status bit7=0.
- 0xFF issued during BUSY → busy restarts at 64 clk, addresses=0, FSM IDLE afterward.
- Only 3 address bytes, then 0x30 → dev_addr_vld on the CLE cycle, dev_addr_cnt=3, row upper byte 0.

Source files
------------

// File: rtl/nf_dev_if_pkg.sv
// rtl/nf_dev_if_pkg.sv - shared widths, NAND opcodes and FSM encodings for nf_dev_if
package nf_dev_if_pkg;

  localparam int NF_DAT_WID = 8;

  localparam logic [7:0] CMD_READ0 = 8'h00;
  localparam logic [7:0] CMD_READ1 = 8'h30;
  localparam logic [7:0] CMD_PROG0 = 8'h80;
  localparam logic [7:0] CMD_PROG1 = 8'h10;
  localparam logic [7:0] CMD_STAT  = 8'h70;
  localparam logic [7:0] CMD_RST   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DIN  = 3'd2,
    ST_BUSY = 3'd3,
    ST_DOUT = 3'd4,
    ST_STAT = 3'd5
  } nf_state_t;

  // Where the FSM goes once the busy window expires
  typedef enum logic [1:0] {
    RET_IDLE = 2'd0,
    RET_DOUT = 2'd1,
    RET_PROG = 2'd2
  } busy_ret_t;

endpackage

// File: rtl/nf_strb_sync.sv
// rtl/nf_strb_sync.sv - 2-flop synchronizer and edge detect for the NAND strobe/data group
module nf_strb_sync #(
  parameter int DAT_WID = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nf_cle,
  input  logic               nf_ale,
  input  logic               nf_web,
  input  logic               nf_reb,
  input  logic [DAT_WID-1:0] nf_din,
  output logic               we_rise,
  output logic               re_fall,
  output logic               cle,
  output logic               ale,
  output logic [DAT_WID-1:0] din
);

  // Group packing: {cle, ale, web, reb, din}; strobes idle high
  localparam logic [DAT_WID+3:0] IDLE_V = {2'b00, 2'b11, {DAT_WID{1'b0}}};

  logic [DAT_WID+3:0] s1, s2;
  logic               web_d, reb_d;

  // Two-stage synchronizer for the whole group plus delayed strobes for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= IDLE_V;
      s2    <= IDLE_V;
      web_d <= 1'b1;
      reb_d <= 1'b1;
    end else begin
      s1    <= {nf_cle, nf_ale, nf_web, nf_reb, nf_din};
      s2    <= s1;
      web_d <= s2[DAT_WID+1];
      reb_d <= s2[DAT_WID];
    end
  end

  // Edge events and aligned bus fields from the second stage
  always_comb begin
    we_rise = s2[DAT_WID+1] & ~web_d;
    re_fall = ~s2[DAT_WID] & reb_d;
    cle     = s2[DAT_WID+3];
    ale     = s2[DAT_WID+2];
    din     = s2[DAT_WID-1:0];
  end

endmodule

// File: rtl/nf_dev_if.sv
// rtl/nf_dev_if.sv - NAND flash device-side bus decoder with busy timing and data/status output
module nf_dev_if
  import nf_dev_if_pkg::*;
#(
  parameter int DAT_WID  = NF_DAT_WID,
  parameter int COL_CYC  = 2,
  parameter int ROW_CYC  = 3,
  parameter int BUSY_CYC = 64,
  parameter int CNT_WID  = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 nf_cle,
  input  logic                 nf_ale,
  input  logic                 nf_web,
  input  logic                 nf_reb,
  input  logic                 nf_wpb,
  input  logic [DAT_WID-1:0]   nf_din,
  output logic [DAT_WID-1:0]   nf_dout,
  output logic                 nf_dir,
  output logic                 nf_rb,
  output logic                 dev_cmd_vld,
  output logic [DAT_WID-1:0]   dev_cmd,
  output logic                 dev_addr_vld,
  output logic [8*COL_CYC-1:0] dev_col_addr,
  output logic [8*ROW_CYC-1:0] dev_row_addr,
  output logic [2:0]           dev_addr_cnt,
  output logic                 dev_wdat_vld,
  output logic [DAT_WID-1:0]   dev_wdat,
  output logic                 dev_rdat_rd,
  input  logic [DAT_WID-1:0]   dev_rdat,
  output logic [CNT_WID-1:0]   dev_dat_cnt,
  output logic                 dev_prog_done
);

  localparam int ADR_TOT = COL_CYC + ROW_CYC;
  localparam int BW      = $clog2(BUSY_CYC) + 1;

  nf_state_t state, state_nxt, stat_ret;
  busy_ret_t busy_ret;
  logic [BW-1:0] busy_cnt;

  logic we_rise, re_fall, s_cle, s_ale;
  logic [DAT_WID-1:0] s_din;

  logic busy, cmd_ev, ff_ev, cmd_ok, addr_ev, addr_take, addr_full, din_ev, re_ev, wdat_ok;
  logic addr_open, addr_drop;
  logic [2:0] addr_k, k_cur, k_new;
  logic [8*COL_CYC-1:0] col_nxt;
  logic [8*ROW_CYC-1:0] row_nxt;
  logic [DAT_WID-1:0] status;

  nf_strb_sync #(.DAT_WID(DAT_WID)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .nf_cle  (nf_cle),
    .nf_ale  (nf_ale),
    .nf_web  (nf_web),
    .nf_reb  (nf_reb),
    .nf_din  (nf_din),
    .we_rise (we_rise),
    .re_fall (re_fall),
    .cle     (s_cle),
    .ale     (s_ale),
    .din     (s_din)
  );

  // Bus cycle classification, address byte placement and status byte
  always_comb begin
    busy      = (state == ST_BUSY);
    cmd_ev    = we_rise & s_cle & ~s_ale;
    ff_ev     = cmd_ev & (s_din == CMD_RST);
    cmd_ok    = cmd_ev & (~busy | ff_ev);
    addr_ev   = we_rise & s_ale & ~s_cle & ~busy;
    addr_take = addr_ev & ~addr_drop;
    din_ev    = we_rise & ~s_cle & ~s_ale & ~busy;
    re_ev     = re_fall & ~we_rise & ~busy;
    wdat_ok   = din_ev & nf_wpb &
                ((state == ST_DIN) || (state == ST_ADDR && dev_cmd == CMD_PROG0));
    k_cur     = addr_open ? addr_k : 3'd0;
    k_new     = (k_cur == 3'd7) ? 3'd7 : k_cur + 3'd1;
    addr_full = addr_take & (int'(k_new) == ADR_TOT);
    col_nxt   = addr_open ? dev_col_addr : '0;
    row_nxt   = addr_open ? dev_row_addr : '0;
    for (int i = 0; i < COL_CYC; i++)
      if (int'(k_cur) == i) col_nxt[8*i +: 8] = s_din[7:0];
    for (int i = 0; i < ROW_CYC; i++)
      if (int'(k_cur) == COL_CYC + i) row_nxt[8*i +: 8] = s_din[7:0];
    status    = {nf_wpb, ~busy, 1'b1, {(DAT_WID-3){1'b0}}};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state decode
  always_comb begin
    state_nxt = state;
    if (cmd_ok) begin
      unique case (s_din)
        CMD_READ0: state_nxt = (state == ST_STAT && stat_ret == ST_DOUT) ? ST_DOUT : ST_ADDR;
        CMD_PROG0: state_nxt = ST_ADDR;
        CMD_READ1, CMD_PROG1, CMD_RST: state_nxt = ST_BUSY;
        CMD_STAT:  state_nxt = ST_STAT;
        default:   state_nxt = ST_IDLE;
      endcase
    end else if (busy) begin
      if (busy_cnt == '0) state_nxt = (busy_ret == RET_DOUT) ? ST_DOUT : ST_IDLE;
    end else if (state == ST_ADDR && dev_cmd == CMD_PROG0 && (addr_full || din_ev)) begin
      state_nxt = ST_DIN;
    end
  end

  // FSM outputs: pin direction and ready/busy
  always_comb begin
    nf_rb  = (state != ST_BUSY);
    nf_dir = (state == ST_DOUT) || (state == ST_STAT);
  end

  // Command, address, data and busy-timer datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nf_dout <= '0;  dev_cmd_vld <= 1'b0;  dev_cmd <= '0;  dev_addr_vld <= 1'b0;
      dev_col_addr <= '0;  dev_row_addr <= '0;  dev_addr_cnt <= '0;  dev_wdat_vld <= 1'b0;
      dev_wdat <= '0;  dev_rdat_rd <= 1'b0;  dev_dat_cnt <= '0;  dev_prog_done <= 1'b0;
      addr_open <= 1'b0;  addr_drop <= 1'b0;  addr_k <= '0;
      busy_cnt <= '0;  busy_ret <= RET_IDLE;  stat_ret <= ST_IDLE;
    end else begin
      dev_cmd_vld   <= 1'b0;
      dev_addr_vld  <= 1'b0;
      dev_wdat_vld  <= 1'b0;
      dev_rdat_rd   <= 1'b0;
      dev_prog_done <= 1'b0;
      if (cmd_ok) begin
        dev_cmd     <= s_din;
        dev_cmd_vld <= 1'b1;
        dev_dat_cnt <= '0;
        addr_drop   <= 1'b0;
      end
      if (din_ev) addr_drop <= 1'b0;
      // Address bytes accumulate; phase closes when full or on the next command/data cycle
      if (addr_take) begin
        addr_k       <= k_new;
        dev_col_addr <= col_nxt;
        dev_row_addr <= row_nxt;
        if (addr_full) begin
          addr_open    <= 1'b0;
          addr_drop    <= 1'b1;
          dev_addr_vld <= 1'b1;
          dev_addr_cnt <= k_new;
        end else begin
          addr_open    <= 1'b1;
        end
      end else if (addr_open && (cmd_ok || din_ev)) begin
        addr_open    <= 1'b0;
        dev_addr_vld <= 1'b1;
        dev_addr_cnt <= addr_k;
      end
      if (ff_ev) begin
        dev_col_addr <= '0;
        dev_row_addr <= '0;
        dev_addr_cnt <= '0;
        addr_open    <= 1'b0;
        addr_drop    <= 1'b0;
        addr_k       <= '0;
      end
      if (wdat_ok) begin
        dev_wdat_vld <= 1'b1;
        dev_wdat     <= s_din;
        dev_dat_cnt  <= dev_dat_cnt + CNT_WID'(1);
      end
      if (re_ev && state == ST_DOUT) begin
        nf_dout     <= dev_rdat;
        dev_rdat_rd <= 1'b1;
        dev_dat_cnt <= dev_dat_cnt + CNT_WID'(1);
      end else if (re_ev && state == ST_STAT) begin
        nf_dout     <= status;
      end
      if (cmd_ok && (s_din == CMD_READ1 || s_din == CMD_PROG1 || s_din == CMD_RST)) begin
        busy_cnt <= BW'(BUSY_CYC - 1);
        busy_ret <= (s_din == CMD_READ1) ? RET_DOUT :
                    (s_din == CMD_PROG1) ? RET_PROG : RET_IDLE;
      end else if (busy && busy_cnt != '0) begin
        busy_cnt <= busy_cnt - BW'(1);
      end
      if (busy && !ff_ev && busy_cnt == '0 && busy_ret == RET_PROG) dev_prog_done <= 1'b1;
      if (cmd_ok && s_din == CMD_STAT && state != ST_STAT) stat_ret <= state;
    end
  end

endmodule

// File: tb/tb_nf_dev_if.sv
// tb/tb_nf_dev_if.sv - directed self-checking bench for nf_dev_if
module tb_nf_dev_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nf_cle = 1'b0, nf_ale = 1'b0, nf_web = 1'b1, nf_reb = 1'b1, nf_wpb = 1'b1;
  logic [7:0]  nf_din = 8'h00;
  logic [7:0]  nf_dout;
  logic        nf_dir, nf_rb;
  logic        dev_cmd_vld, dev_addr_vld, dev_wdat_vld, dev_rdat_rd, dev_prog_done;
  logic [7:0]  dev_cmd, dev_wdat, dev_rdat;
  logic [15:0] dev_col_addr;
  logic [23:0] dev_row_addr;
  logic [2:0]  dev_addr_cnt;
  logic [13:0] dev_dat_cnt;

  int checks = 0;
  int errors = 0;

  int n_cmd = 0, n_addr = 0, n_wdat = 0, n_rd = 0, n_done = 0, n_rb_low = 0, n_addr_on_cmd = 0;
  int ff_base = 0;
  logic [7:0] wq[$];
  logic [7:0] rd_idx = 8'h00;

  always #5 clk = ~clk;

  assign dev_rdat = 8'hA0 + rd_idx;

  nf_dev_if dut (
    .clk(clk), .rst_n(rst_n), .nf_cle(nf_cle), .nf_ale(nf_ale), .nf_web(nf_web),
    .nf_reb(nf_reb), .nf_wpb(nf_wpb), .nf_din(nf_din), .nf_dout(nf_dout), .nf_dir(nf_dir),
    .nf_rb(nf_rb), .dev_cmd_vld(dev_cmd_vld), .dev_cmd(dev_cmd), .dev_addr_vld(dev_addr_vld),
    .dev_col_addr(dev_col_addr), .dev_row_addr(dev_row_addr), .dev_addr_cnt(dev_addr_cnt),
    .dev_wdat_vld(dev_wdat_vld), .dev_wdat(dev_wdat), .dev_rdat_rd(dev_rdat_rd),
    .dev_rdat(dev_rdat), .dev_dat_cnt(dev_dat_cnt), .dev_prog_done(dev_prog_done)
  );

  // Backend read pointer and pulse/busy bookkeeping
  always @(posedge clk) begin
    if (!rst_n) rd_idx <= 8'h00;
    else if (dev_rdat_rd) rd_idx <= rd_idx + 8'h01;
    if (dev_cmd_vld) n_cmd <= n_cmd + 1;
    if (dev_addr_vld) n_addr <= n_addr + 1;
    if (dev_addr_vld && dev_cmd_vld) n_addr_on_cmd <= n_addr_on_cmd + 1;
    if (dev_wdat_vld) begin n_wdat <= n_wdat + 1; wq.push_back(dev_wdat); end
    if (dev_rdat_rd) n_rd <= n_rd + 1;
    if (dev_prog_done) n_done <= n_done + 1;
    if (!nf_rb) n_rb_low <= n_rb_low + 1;
    if (dev_cmd_vld && dev_cmd == 8'hFF) ff_base <= n_rb_low;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic we_cyc(input logic c, input logic a, input logic [7:0] d);
    @(negedge clk);
    nf_cle = c; nf_ale = a; nf_din = d; nf_web = 1'b0;
    repeat (4) @(negedge clk);
    nf_web = 1'b1;
    repeat (4) @(negedge clk);
    nf_cle = 1'b0; nf_ale = 1'b0;
  endtask

  task automatic rd_cyc();
    @(negedge clk);
    nf_reb = 1'b0;
    repeat (4) @(negedge clk);
    nf_reb = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!nf_rb && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) chk({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_addr5();
    we_cyc(1'b0, 1'b1, 8'h02); we_cyc(1'b0, 1'b1, 8'h03); we_cyc(1'b0, 1'b1, 8'hAA);
    we_cyc(1'b0, 1'b1, 8'h55); we_cyc(1'b0, 1'b1, 8'hCC);
  endtask

  int b_cmd, b_addr, b_wdat, b_rd, b_done, b_low, b_aoc;

  initial begin
    repeat (3) @(negedge clk);
    // Reset values
    chk("rst_rb", nf_rb, 1);
    chk("rst_dir", nf_dir, 0);
    chk("rst_dout", nf_dout, 0);
    chk("rst_cmd", dev_cmd, 0);
    chk("rst_col", dev_col_addr, 0);
    chk("rst_row", dev_row_addr, 0);
    chk("rst_acnt", dev_addr_cnt, 0);
    chk("rst_dcnt", dev_dat_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Status read
    b_cmd = n_cmd; b_rd = n_rd;
    we_cyc(1'b1, 1'b0, 8'h70);
    chk("stat_cmd_pulse", n_cmd - b_cmd, 1);
    chk("stat_cmd", dev_cmd, 8'h70);
    rd_cyc();
    chk("stat_dout0", nf_dout, 8'hE0);
    chk("stat_dir", nf_dir, 1);
    rd_cyc();
    chk("stat_dout1", nf_dout, 8'hE0);
    chk("stat_no_rd", n_rd - b_rd, 0);

    // Page read
    b_addr = n_addr;
    we_cyc(1'b1, 1'b0, 8'h00);
    send_addr5();
    chk("rd_addr_pulse", n_addr - b_addr, 1);
    chk("rd_col", dev_col_addr, 16'h0302);
    chk("rd_row", dev_row_addr, 24'hCC55AA);
    chk("rd_acnt", dev_addr_cnt, 5);
    b_low = n_rb_low;
    we_cyc(1'b1, 1'b0, 8'h30);
    chk("rd_busy_now", nf_rb, 0);
    wait_ready("rd");
    chk("rd_busy_len", n_rb_low - b_low, 64);
    chk("rd_dir", nf_dir, 1);
    b_rd = n_rd;
    for (int i = 0; i < 16; i++) rd_cyc();
    chk("rd_pulses", n_rd - b_rd, 16);
    chk("rd_dcnt", dev_dat_cnt, 16);
    chk("rd_dout_last", nf_dout, 8'hAF);

    // Program with write enabled
    b_wdat = n_wdat; b_done = n_done;
    we_cyc(1'b1, 1'b0, 8'h80);
    chk("pg_dcnt_clr", dev_dat_cnt, 0);
    send_addr5();
    for (int i = 1; i <= 16; i++) we_cyc(1'b0, 1'b0, 8'(i));
    chk("pg_wdat_pulses", n_wdat - b_wdat, 16);
    for (int i = 0; i < 16; i++) chk("pg_wdat_val", wq[b_wdat + i], i + 1);
    chk("pg_dcnt", dev_dat_cnt, 16);
    b_low = n_rb_low;
    we_cyc(1'b1, 1'b0, 8'h10);
    wait_ready("pg");
    chk("pg_busy_len", n_rb_low - b_low, 64);
    chk("pg_done", n_done - b_done, 1);
    chk("pg_dir", nf_dir, 0);

    // Program with write protect
    nf_wpb = 1'b0;
    b_wdat = n_wdat; b_done = n_done;
    we_cyc(1'b1, 1'b0, 8'h80);
    send_addr5();
    for (int i = 1; i <= 16; i++) we_cyc(1'b0, 1'b0, 8'(i));
    we_cyc(1'b1, 1'b0, 8'h10);
    wait_ready("wp");
    chk("wp_no_wdat", n_wdat - b_wdat, 0);
    chk("wp_done", n_done - b_done, 1);
    we_cyc(1'b1, 1'b0, 8'h70);
    rd_cyc();
    chk("wp_status", nf_dout, 8'h60);
    nf_wpb = 1'b1;

    // Reset command during busy
    we_cyc(1'b1, 1'b0, 8'h00);
    send_addr5();
    we_cyc(1'b1, 1'b0, 8'h30);
    repeat (10) @(negedge clk);
    we_cyc(1'b1, 1'b0, 8'hFF);
    chk("ff_cmd", dev_cmd, 8'hFF);
    chk("ff_col", dev_col_addr, 0);
    chk("ff_row", dev_row_addr, 0);
    wait_ready("ff");
    chk("ff_busy_len", n_rb_low - ff_base, 64);
    chk("ff_idle_dir", nf_dir, 0);
    chk("ff_acnt", dev_addr_cnt, 0);

    // Short address phase closed by the confirm command
    b_addr = n_addr; b_aoc = n_addr_on_cmd;
    we_cyc(1'b1, 1'b0, 8'h00);
    we_cyc(1'b0, 1'b1, 8'h11); we_cyc(1'b0, 1'b1, 8'h22); we_cyc(1'b0, 1'b1, 8'h33);
    chk("sh_open", n_addr - b_addr, 0);
    we_cyc(1'b1, 1'b0, 8'h30);
    chk("sh_pulse", n_addr - b_addr, 1);
    chk("sh_on_cmd", n_addr_on_cmd - b_aoc, 1);
    chk("sh_acnt", dev_addr_cnt, 3);
    chk("sh_col", dev_col_addr, 16'h2211);
    chk("sh_row", dev_row_addr, 24'h000033);
    wait_ready("sh");
    chk("sh_dir", nf_dir, 1);

    // Asynchronous reset mid-busy
    we_cyc(1'b1, 1'b0, 8'h30);
    repeat (5) @(negedge clk);
    chk("ar_busy", nf_rb, 0);
    rst_n = 1'b0;
    #1;
    chk("ar_rb", nf_rb, 1);
    chk("ar_cmd", dev_cmd, 0);
    chk("ar_col", dev_col_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
